instr_mem: RTL and testbench



---
 rtl/instr_mem_pkg.sv | 12 +
 rtl/instr_mem_array.sv | 28 ++
 rtl/instr_mem.sv | 151 +++++++++++++++
 tb/tb_instr_mem.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_e;

    localparam logic [31:0] IMEM_NOP = 32'h0007_8000;

endpackage

// File: rtl/instr_mem_array.sv
// 1W1R synchronous RAM; the read register only updates on rd_en so a
// held fetch keeps its data without extra muxing in the top level.
module instr_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Loadable instruction memory: self-clears to NOP, accepts a program over a
// valid/ready port and serves one-cycle-latency fetches with stall hold.
//
//   state | meaning
//   CLEAR | writing NOP_WORD to every word, one per cycle
//   RUN   | serving fetches, waiting for ld_start
//   LOAD  | accepting program words at the load pointer
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 64,
    parameter int                 ADDR_W   = $clog2(DEPTH),
    parameter logic [DATA_W-1:0]  NOP_WORD = IMEM_NOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stall,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              oob,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    imem_state_e state, state_next;

    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] ld_ptr;
    logic              in_range;
    logic              fetch_go;
    logic              beat;
    logic              ld_end;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] inst_alt;
    logic              src_ram;
    logic              inst_valid_q;
    logic              oob_q;
    logic              ld_done_q;

    assign in_range = ({1'b0, addr} < DEPTH_C);
    assign fetch_go = (state == RUN) && fetch_en && !stall;
    assign beat     = (state == LOAD) && ld_valid;
    assign ld_end   = beat && !ld_start && (ld_last || (ld_ptr == LAST_C));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        we         = 1'b0;
        wr_addr    = ld_ptr;
        wr_data    = ld_data;
        case (state)
            CLEAR: begin
                we      = 1'b1;
                wr_addr = clr_ptr;
                wr_data = NOP_WORD;
                if (clr_ptr == LAST_C) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ld_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // a restart drops any beat presented in the same cycle
                we = beat && !ld_start;
                if (ld_end) begin
                    state_next = RUN;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_ptr      <= '0;
            ld_ptr       <= '0;
            inst_valid_q <= 1'b0;
            oob_q        <= 1'b0;
            src_ram      <= 1'b0;
            inst_alt     <= NOP_WORD;
            ld_done_q    <= 1'b0;
        end else begin
            ld_done_q <= ld_end;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (ld_start && (state != CLEAR)) begin
                ld_ptr <= '0;
            end else if ((state == LOAD) && we) begin
                ld_ptr <= ld_ptr + 1'b1;
            end
            if (!stall) begin
                inst_valid_q <= fetch_go;
                oob_q        <= fetch_go && !in_range;
                if (fetch_go) begin
                    // out-of-range fetches return NOP from the side register
                    src_ram <= in_range;
                    if (!in_range) begin
                        inst_alt <= NOP_WORD;
                    end
                end
            end
        end
    end

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (fetch_go && in_range),
        .rd_addr (addr),
        .rd_data (rd_data)
    );

    assign inst       = src_ram ? rd_data : inst_alt;
    assign inst_valid = inst_valid_q;
    assign oob        = oob_q;
    assign ld_ready   = (state == LOAD);
    assign ld_done    = ld_done_q;
    assign busy       = (state != RUN);

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: a 64-word and a 48-word instance
// checked against an array-based reference model.
module tb_instr_mem;

    localparam int          DW   = 32;
    localparam int          D    = 64;
    localparam int          AW   = 6;
    localparam int          D_B  = 48;
    localparam int          AW_B = 6;
    localparam logic [31:0] NOP  = 32'h0007_8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n    = 1'b0;
    logic          fetch_en = 1'b0;
    logic          stall    = 1'b0;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_last  = 1'b0;
    logic [AW-1:0] addr     = '0;
    logic [DW-1:0] ld_data  = '0;
    logic [DW-1:0] inst;
    logic          inst_valid, oob, ld_ready, ld_done, busy;

    logic            fetch_en_b = 1'b0;
    logic            zero_b     = 1'b0;
    logic [AW_B-1:0] addr_b     = '0;
    logic [DW-1:0]   ld_data_b  = '0;
    logic [DW-1:0]   inst_b;
    logic            inst_valid_b, oob_b, ld_ready_b, ld_done_b, busy_b;

    instr_mem #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .addr(addr), .stall(stall),
        .inst(inst), .inst_valid(inst_valid), .oob(oob),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
    );

    instr_mem #(.DATA_W(DW), .DEPTH(D_B), .ADDR_W(AW_B), .NOP_WORD(NOP)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en_b), .addr(addr_b), .stall(zero_b),
        .inst(inst_b), .inst_valid(inst_valid_b), .oob(oob_b),
        .ld_start(zero_b), .ld_valid(zero_b), .ld_data(ld_data_b), .ld_last(zero_b),
        .ld_ready(ld_ready_b), .ld_done(ld_done_b), .busy(busy_b)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] model [D];
    logic [DW-1:0] words [70];
    logic [DW-1:0] exp_inst;
    logic          exp_valid;
    logic          exp_oob;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_inst"},  inst,       exp_inst);
        chk({tag, "_valid"}, inst_valid, exp_valid);
        chk({tag, "_oob"},   oob,        exp_oob);
    endtask

    task automatic do_reset();
        int cyc;
        int cyc_b;
        rst_n = 1'b0; fetch_en = 1'b0; stall = 1'b0; fetch_en_b = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        tick(); tick();
        for (int i = 0; i < D; i++) model[i] = NOP;
        exp_inst = NOP; exp_valid = 1'b0; exp_oob = 1'b0;
        chk_out("rst");
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_ld_done",  ld_done,  0);
        chk("rst_busy",     busy,     1);
        chk("rst_busy_b",   busy_b,   1);
        rst_n = 1'b1;
        cyc = 0; cyc_b = 0;
        while ((busy || busy_b) && cyc < 200) begin
            tick();
            cyc++;
            if (!busy_b && cyc_b == 0) cyc_b = cyc;
        end
        chk("clear_cycles",   cyc,   D);
        chk("clear_cycles_b", cyc_b, D_B);
    endtask

    task automatic do_fetch(input int a);
        addr = AW'(a); fetch_en = 1'b1; stall = 1'b0;
        tick();
        fetch_en = 1'b0;
        exp_inst = model[a]; exp_valid = 1'b1; exp_oob = 1'b0;
        chk_out($sformatf("fetch%0d", a));
    endtask

    task automatic load_run(input int n, input bit use_last, input bit gaps);
        int ptr, acc, guard, i;
        bit done, beat, fin;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0; exp_valid = 1'b0;
        chk("ld_ready_rise", ld_ready, 1);
        chk("busy_in_load",  busy,     1);
        ptr = 0; acc = 0; guard = 0; i = 0; done = 0;
        while (i < n && guard < 2000) begin
            guard++;
            ld_valid = !gaps || ($urandom_range(0, 3) != 0);
            ld_data  = words[i];
            ld_last  = use_last && (i == n - 1);
            chk("ld_ready", ld_ready, !done);
            beat = ld_valid && !done;
            if (ld_valid && ld_ready) acc++;
            tick();
            fin = 0;
            if (ld_valid) begin
                i++;
                if (beat) begin
                    model[ptr] = ld_data;
                    ptr++;
                    if (ld_last || ptr == D) begin
                        done = 1; fin = 1;
                    end
                end
            end
            chk("ld_done", ld_done, fin);
            if (fin) chk("busy_fall_with_done", busy, 0);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        tick();
        chk("ld_done_one_cycle", ld_done, 0);
        chk("busy_after_load",   busy,    0);
        chk("ld_words_accepted", acc, (n < D) ? n : D);
    endtask

    initial begin
        do_reset();

        // cleared memory, out-of-range and in-range on the 48-word instance
        do_fetch(9);
        addr_b = 6'd50; fetch_en_b = 1'b1;
        tick();
        chk("b_oob_inst", inst_b, NOP);
        chk("b_oob_valid", inst_valid_b, 1);
        chk("b_oob_flag", oob_b, 1);
        addr_b = 6'd47;
        tick();
        fetch_en_b = 1'b0;
        chk("b_last_inst", inst_b, NOP);
        chk("b_last_oob", oob_b, 0);
        tick();
        chk("b_idle_valid", inst_valid_b, 0);
        chk("b_idle_oob", oob_b, 0);
        chk("b_idle_ready", ld_ready_b, 0);
        chk("b_idle_done", ld_done_b, 0);

        // load 10 words with gaps, ld_last on word 9
        for (int i = 0; i < 70; i++) words[i] = $urandom;
        words[1] = 32'h8008_0001;
        words[9] = 32'h0C32_0000;
        load_run(10, 1'b1, 1'b1);
        do_fetch(1);
        chk("word1_const", inst, 32'h8008_0001);
        do_fetch(9);
        chk("word9_const", inst, 32'h0C32_0000);
        do_fetch(10);
        chk("word10_nop", inst, NOP);

        // stall hold with fetch_en asserted
        do_fetch(1);
        stall = 1'b1; fetch_en = 1'b1; addr = 6'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("stall_hold");
        end
        stall = 1'b0;
        tick();
        fetch_en = 1'b0;
        exp_inst = model[2]; exp_valid = 1'b1;
        chk_out("after_stall");
        tick();
        exp_valid = 1'b0;
        chk_out("idle_keep");

        // random fetch / stall / idle traffic
        for (int c = 0; c < 300; c++) begin
            stall    = ($urandom_range(0, 3) == 0);
            fetch_en = $urandom_range(0, 1);
            addr     = AW'($urandom_range(0, D - 1));
            tick();
            if (!stall) begin
                exp_valid = fetch_en;
                exp_oob   = 1'b0;
                if (fetch_en) exp_inst = model[addr];
            end
            chk_out("rand");
        end
        stall = 1'b0; fetch_en = 1'b0;
        tick();

        // overflow: 70 words offered without ld_last
        for (int i = 0; i < 70; i++) words[i] = $urandom;
        load_run(70, 1'b0, 1'b0);
        do_fetch(63);
        chk("word63_64th", inst, words[63]);
        do_fetch(0);

        // restart after 3 words; the beat alongside ld_start is dropped
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_data = $urandom;
            tick();
            model[k] = ld_data;
            chk("restart_pre_done", ld_done, 0);
        end
        ld_start = 1'b1; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_start = 1'b0;
        chk("restart_no_done", ld_done, 0);
        chk("restart_ready", ld_ready, 1);
        for (int k = 0; k < 2; k++) begin
            ld_data = $urandom; ld_last = (k == 1);
            tick();
            model[k] = ld_data;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("restart_done", ld_done, 1);
        chk("restart_busy", busy, 0);
        do_fetch(0);
        do_fetch(1);
        do_fetch(2);
        do_fetch(3);

        // reset in the middle of a load re-clears everything
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1; ld_data = $urandom;
            tick();
        end
        do_reset();
        do_fetch(0);
        do_fetch(1);
        chk("reset_word1_nop", inst, NOP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
